// File: rtl/arith_digit_serial_unit.sv
// arith_digit_serial_unit
// Digit-serial arithmetic unit. WIDTH-bit operands are added DIGIT bits per
// clock through one DIGIT-wide carry chain, LSB first, with the carry held in
// a register between digits. Every op is reduced at capture time to
// A + b' + c0, so the datapath only ever adds.
// Optional build macro: ARITH_SAT_EN clamps signed overflow to the signed
// max/min for the arithmetic ops (MOV and illegal are never clamped).
module arith_digit_serial_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       opsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             err
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUBWB  = 3'd1;
    localparam logic [2:0] OP_MOV    = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_INC    = 3'd4;
    localparam logic [2:0] OP_DEC    = 3'd5;
    localparam logic [2:0] OP_ADDINC = 3'd6;
    localparam logic [2:0] OP_ILL    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_r;

    logic [WIDTH-1:0] b_eff;
    logic             c0_eff;
    logic             accept;
    logic             last_digit;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] res_final;
    logic             cout_final;
    logic             ovf_final;

    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             neg_r;
    logic             err_r;

    assign accept     = (state == S_IDLE) && in_valid;
    assign last_digit = (cnt == CW'(NDIG - 1));

    // Reduce every op to an addend b' and a carry-in c0 for A + b' + c0
    always_comb begin
        b_eff  = '0;
        c0_eff = 1'b0;
        case (opsel)
            OP_ADD:    begin b_eff = b;    c0_eff = cin;  end
            OP_SUBWB:  begin b_eff = ~b;   c0_eff = ~cin; end
            OP_MOV:    begin b_eff = '0;   c0_eff = 1'b0; end
            OP_SUB:    begin b_eff = ~b;   c0_eff = 1'b1; end
            OP_INC:    begin b_eff = '0;   c0_eff = 1'b1; end
            OP_DEC:    begin b_eff = '1;   c0_eff = 1'b0; end
            OP_ADDINC: begin b_eff = b;    c0_eff = 1'b1; end
            default:   begin b_eff = '0;   c0_eff = 1'b0; end
        endcase
    end

    // One digit of the carry chain plus the carry into the digit's top bit
    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
        msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
    end

    // New digits enter the result register from the top, so after the last
    // digit the LSB digit has reached bit 0
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign res_shift = dsum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign res_shift = {dsum[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Final result and flags as they will be latched on the last digit
    always_comb begin
        res_final  = res_shift;
        cout_final = dsum[DIGIT];
        ovf_final  = msb_cin ^ dsum[DIGIT];
        if (op_r == OP_ILL) begin
            res_final  = '0;
            cout_final = 1'b0;
            ovf_final  = 1'b0;
        end else if (op_r == OP_MOV) begin
            cout_final = 1'b0;
            ovf_final  = 1'b0;
        end
`ifdef ARITH_SAT_EN
        else if (ovf_final) begin
            res_final = res_shift[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                           : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture, run NDIG digits, hold until consumed
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)   state_nxt = S_RUN;
            S_RUN:   if (last_digit) state_nxt = S_DONE;
            S_DONE:  if (out_ready)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath: capture operands on accept, then shift one digit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            op_r   <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            err_r  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= c0_eff;
            cnt   <= '0;
            op_r  <= opsel;
        end else if (state == S_RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= dsum[DIGIT];
            cnt   <= cnt + CW'(1);
            if (last_digit) begin
                res_sh <= res_final;
                cout_r <= cout_final;
                ovf_r  <= ovf_final;
                zero_r <= (res_final == '0);
                neg_r  <= res_final[WIDTH-1];
                err_r  <= (op_r == OP_ILL);
            end else begin
                res_sh <= res_shift;
            end
        end
    end

    assign result = res_sh;
    assign cout   = cout_r;
    assign ovf    = ovf_r;
    assign zero   = zero_r;
    assign neg    = neg_r;
    assign err    = err_r;

endmodule

// File: tb/tb_arith_digit_serial_unit.sv
// tb_arith_digit_serial_unit
// Randomised and directed bench for arith_digit_serial_unit. The main instance
// uses the default geometry; two extra instances (DIGIT=1 and DIGIT=WIDTH)
// share the operand bus and are driven by their own valid line.
// Honours ARITH_SAT_EN in the reference model when defined.
module tb_arith_digit_serial_unit;

    localparam int W    = 32;
    localparam int DG   = 4;
    localparam int NDIG = W / DG;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [2:0]   opsel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout, ovf, zero, neg, err;

    logic         iv1, ir1, ov1, c1, o1, z1, n1, e1;
    logic [W-1:0] r1;
    logic         iv32, ir32, ov32, c32, o32, z32, n32, e32;
    logic [W-1:0] r32;

    int errors = 0;
    int checks = 0;

    logic mBusy;
    logic mDone;
    int   mLeft;
    exp_t mExp;

    always #5 clk = ~clk;

    arith_digit_serial_unit #(.WIDTH(W), .DIGIT(DG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .opsel(opsel), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf),
        .zero(zero), .neg(neg), .err(err)
    );

    arith_digit_serial_unit #(.WIDTH(W), .DIGIT(1)) dutD1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .opsel(opsel), .out_valid(ov1),
        .out_ready(out_ready), .result(r1), .cout(c1), .ovf(o1),
        .zero(z1), .neg(n1), .err(e1)
    );

    arith_digit_serial_unit #(.WIDTH(W), .DIGIT(W)) dutD32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a), .b(b), .cin(cin), .opsel(opsel), .out_valid(ov32),
        .out_ready(out_ready), .result(r32), .cout(c32), .ovf(o32),
        .zero(z32), .neg(n32), .err(e32)
    );

    // Reference result from plain signed/unsigned arithmetic on the operands
    function automatic exp_t refModel(input logic [2:0] op, input logic [W-1:0] ua,
                                      input logic [W-1:0] ub, input logic ci);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] va, vb, u;
        logic        c;
        sa = longint'($signed(ua));
        sb = longint'($signed(ub));
        va = {32'd0, ua};
        vb = {32'd0, ub};
        s  = 0;
        u  = 64'd0;
        c  = 1'b0;
        e  = '0;
        case (op)
            3'd0: begin s = sa + sb + longint'(ci); u = va + vb + 64'(ci); c = u[32]; end
            3'd1: begin s = sa - sb - longint'(ci); u = va - vb - 64'(ci); c = (va >= vb + 64'(ci)); end
            3'd2: begin s = sa; u = va; c = 1'b0; end
            3'd3: begin s = sa - sb; u = va - vb; c = (va >= vb); end
            3'd4: begin s = sa + 1; u = va + 64'd1; c = (ua == 32'hFFFF_FFFF); end
            3'd5: begin s = sa - 1; u = va - 64'd1; c = (ua != 32'd0); end
            3'd6: begin s = sa + sb + 1; u = va + vb + 64'd1; c = u[32]; end
            default: begin s = 0; u = 64'd0; c = 1'b0; end
        endcase
        e.res  = u[31:0];
        e.cout = c;
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef ARITH_SAT_EN
        if (e.ovf) e.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.err  = (op == 3'd7);
        e.zero = (e.res == 32'd0);
        e.neg  = e.res[31];
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Transaction-level model: one op in flight, visible NDIG cycles after accept
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy <= 1'b0;
            mDone <= 1'b0;
            mLeft <= 0;
            mExp  <= '0;
        end else if (!mBusy && !mDone) begin
            if (in_valid) begin
                mBusy <= 1'b1;
                mLeft <= NDIG;
                mExp  <= refModel(opsel, a, b, cin);
            end
        end else if (mBusy) begin
            if (mLeft == 1) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
            end
            mLeft <= mLeft - 1;
        end else if (out_ready) begin
            mDone <= 1'b0;
        end
    end

    // Compare the main instance against the model on every falling edge
    always @(negedge clk) begin
        checkFlag("in_ready", in_ready, !mBusy && !mDone);
        checkFlag("out_valid", out_valid, mDone);
        if (mDone) begin
            checkOutput("result", result, mExp.res);
            checkFlag("cout", cout, mExp.cout);
            checkFlag("ovf", ovf, mExp.ovf);
            checkFlag("zero", zero, mExp.zero);
            checkFlag("neg", neg, mExp.neg);
            checkFlag("err", err, mExp.err);
        end
    end

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present one op for a single accepting cycle, then scramble the bus
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] va,
                                 input logic [W-1:0] vb, input logic ci);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) checkFlag("wait_in_ready", in_ready, 1'b1);
        opsel    = op;
        a        = va;
        b        = vb;
        cin      = ci;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom_range(0, 1));
        opsel    = 3'($urandom_range(0, 7));
    endtask

    // Wait for out_valid with a bound, optionally toggling in_valid meanwhile
    task automatic waitDone(input bit noise);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!out_valid) checkFlag("wait_out_valid", out_valid, 1'b1);
    endtask

    // Hold backpressure for some cycles, then consume the result
    task automatic releaseOp(input int hold, input bit noise);
        for (int i = 0; i < hold; i++) begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic checkLit(input string tag, input logic [W-1:0] er, input logic ec,
                            input logic eo, input logic ez, input logic en, input logic ee);
        checkOutput({tag, "_result"}, result, er);
        checkFlag({tag, "_cout"}, cout, ec);
        checkFlag({tag, "_ovf"}, ovf, eo);
        checkFlag({tag, "_zero"}, zero, ez);
        checkFlag({tag, "_neg"}, neg, en);
        checkFlag({tag, "_err"}, err, ee);
    endtask

    task automatic directedOp(input string tag, input logic [2:0] op, input logic [W-1:0] va,
                              input logic [W-1:0] vb, input logic ci, input logic [W-1:0] er,
                              input logic ec, input logic eo, input logic ez, input logic en,
                              input logic ee);
        applyStimulus(op, va, vb, ci);
        waitDone(1'b0);
        checkLit(tag, er, ec, eo, ez, en, ee);
        releaseOp(0, 1'b0);
        checkFlag({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    // Run the same op through the DIGIT=1 and DIGIT=WIDTH instances
    task automatic geometryOp();
        int lat1, lat32;
        lat1  = -1;
        lat32 = -1;
        opsel = 3'd0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0001;
        cin   = 1'b0;
        iv1   = 1'b1;
        iv32  = 1'b1;
        for (int k = 1; k <= 40 && (lat1 < 0 || lat32 < 0); k++) begin
            @(negedge clk);
            iv1  = 1'b0;
            iv32 = 1'b0;
            if (ov1 && lat1 < 0)   lat1  = k - 1;
            if (ov32 && lat32 < 0) lat32 = k - 1;
        end
        checkOutput("d1_latency", lat1, 32);
        checkOutput("d32_latency", lat32, 1);
        checkOutput("d1_result", r1, 32'h0);
        checkFlag("d1_cout", c1, 1'b1);
        checkFlag("d1_zero", z1, 1'b1);
        checkFlag("d1_ovf", o1, 1'b0);
        checkOutput("d32_result", r32, 32'h0);
        checkFlag("d32_cout", c32, 1'b1);
        checkFlag("d32_zero", z32, 1'b1);
        checkFlag("d32_ovf", o32, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkFlag("d1_in_ready_after", ir1, 1'b1);
        checkFlag("d32_in_ready_after", ir32, 1'b1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rop;
        logic         rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        iv1       = 1'b0;
        iv32      = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        opsel     = 3'd0;
        #2;
        checkFlag("reset_in_ready", in_ready, 1'b1);
        checkFlag("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_result", result, 32'h0);
        checkFlag("reset_zero", zero, 1'b0);
        checkFlag("reset_err", err, 1'b0);
        checkFlag("reset_cout", cout, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed ops");
        directedOp("t1_add", 3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ARITH_SAT_EN
        directedOp("t2_sub", 3'd3, 32'h8000_0000, 32'h1, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        directedOp("t2_sub", 3'd3, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        directedOp("t3_subwb", 3'd1, 32'd5, 32'd3, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        directedOp("t3_dec", 3'd5, 32'd0, 32'd99, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        directedOp("t3_addinc", 3'd6, 32'd2, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        directedOp("t3_mov", 3'd2, 32'h1234, 32'hFFFF_FFFF, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        directedOp("t3_inc", 3'd4, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        directedOp("t6_illegal", 3'd7, 32'h55, 32'h66, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(3'd0, 32'd100, 32'd23, 1'b1);
        waitDone(1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            checkOutput("bp_result", result, 32'd124);
            checkFlag("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkFlag("bp_out_valid_held", out_valid, 1'b1);
        releaseOp(0, 1'b0);
        checkFlag("bp_in_ready_after", in_ready, 1'b1);
        @(negedge clk);
        checkFlag("bp_pulse_ignored", in_ready, 1'b1);

        $display("[TB] reset during run");
        applyStimulus(3'd0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkFlag("rst_run_out_valid", out_valid, 1'b0);
        checkFlag("rst_run_in_ready", in_ready, 1'b1);
        checkOutput("rst_run_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        directedOp("t5_add", 3'd0, 32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during done");
        applyStimulus(3'd3, 32'd1, 32'd2, 1'b0);
        waitDone(1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkFlag("rst_done_out_valid", out_valid, 1'b0);
        checkOutput("rst_done_result", result, 32'h0);
        checkFlag("rst_done_neg", neg, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] digit geometry");
        geometryOp();

        $display("[TB] random ops");
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pickOperand();
            rb  = pickOperand();
            rc  = 1'($urandom_range(0, 1));
            applyStimulus(rop, ra, rb, rc);
            waitDone(1'b1);
            releaseOp($urandom_range(0, 3), 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
